// File: rtl/alu_operand_stage_if.sv
// Interface bundle for the ID/EX operand-select stage.
// The master side is decode/forwarding/EX; the slave side is the stage.
interface alu_operand_stage_if #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned CNT_W   = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [XLEN-1:0]    pc;
    logic [RADDR_W-1:0] rs1_addr;
    logic [XLEN-1:0]    rs1_data;
    logic [RADDR_W-1:0] rs2_addr;
    logic [XLEN-1:0]    rs2_data;
    logic [XLEN-1:0]    imm;
    logic [1:0]         asel;
    logic [1:0]         bsel;
    logic               fwd_ex_valid;
    logic [RADDR_W-1:0] fwd_ex_rd;
    logic [XLEN-1:0]    fwd_ex_data;
    logic               fwd_mem_valid;
    logic [RADDR_W-1:0] fwd_mem_rd;
    logic [XLEN-1:0]    fwd_mem_data;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    alu_a;
    logic [XLEN-1:0]    alu_b;
    logic [CNT_W-1:0]   fwd_count;

    modport master (
        output in_valid, pc, rs1_addr, rs1_data, rs2_addr, rs2_data, imm,
               asel, bsel, fwd_ex_valid, fwd_ex_rd, fwd_ex_data,
               fwd_mem_valid, fwd_mem_rd, fwd_mem_data, flush, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, fwd_count
    );

    modport slave (
        input  in_valid, pc, rs1_addr, rs1_data, rs2_addr, rs2_data, imm,
               asel, bsel, fwd_ex_valid, fwd_ex_rd, fwd_ex_data,
               fwd_mem_valid, fwd_mem_rd, fwd_mem_data, flush, out_ready,
        output in_ready, out_valid, alu_a, alu_b, fwd_count
    );
endinterface

// File: rtl/alu_operand_stage.sv
// Registered ALU operand-select stage at the ID/EX boundary: forwarding,
// A/B operand muxing, valid/ready pipeline register and forwarding counter.
module alu_operand_stage #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    alu_operand_stage_if.slave bus
);
    logic               out_valid_q, out_valid_d;
    logic [XLEN-1:0]    alu_a_q, alu_a_d;
    logic [XLEN-1:0]    alu_b_q, alu_b_d;
    logic [CNT_W-1:0]   fwd_count_q, fwd_count_d;

    logic [XLEN-1:0]    rs1_val, rs2_val;
    logic               rs1_hit, rs2_hit;
    logic [XLEN-1:0]    a_sel, b_sel;
    logic               used_fwd;
    logic               accept;

    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.fwd_count = fwd_count_q;

    assign accept = bus.in_valid && bus.in_ready && !bus.flush;

    // Forwarding resolution: EX beats MEM, x0 always reads the register file.
    always_comb begin
        rs1_val = bus.rs1_data;
        rs1_hit = 1'b0;
        if (bus.fwd_ex_valid && (bus.fwd_ex_rd == bus.rs1_addr) && (bus.rs1_addr != '0)) begin
            rs1_val = bus.fwd_ex_data;
            rs1_hit = 1'b1;
        end else if (bus.fwd_mem_valid && (bus.fwd_mem_rd == bus.rs1_addr) && (bus.rs1_addr != '0)) begin
            rs1_val = bus.fwd_mem_data;
            rs1_hit = 1'b1;
        end

        rs2_val = bus.rs2_data;
        rs2_hit = 1'b0;
        if (bus.fwd_ex_valid && (bus.fwd_ex_rd == bus.rs2_addr) && (bus.rs2_addr != '0)) begin
            rs2_val = bus.fwd_ex_data;
            rs2_hit = 1'b1;
        end else if (bus.fwd_mem_valid && (bus.fwd_mem_rd == bus.rs2_addr) && (bus.rs2_addr != '0)) begin
            rs2_val = bus.fwd_mem_data;
            rs2_hit = 1'b1;
        end
    end

    // Operand muxes; a forward only counts when its source is actually selected.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        case (bus.asel)
            2'b01:   a_sel = rs1_val;
            2'b10:   a_sel = bus.pc;
            default: a_sel = '0;
        endcase
        case (bus.bsel)
            2'b01:   b_sel = rs2_val;
            2'b10:   b_sel = bus.imm;
            2'b11:   b_sel = XLEN'(4);
            default: b_sel = '0;
        endcase
        used_fwd = ((bus.asel == 2'b01) && rs1_hit) || ((bus.bsel == 2'b01) && rs2_hit);
    end

    always_comb begin
        out_valid_d = out_valid_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        fwd_count_d = fwd_count_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            alu_a_d     = a_sel;
            alu_b_d     = b_sel;
            if (used_fwd && (fwd_count_q != '1)) begin
                fwd_count_d = fwd_count_q + CNT_W'(1);
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            fwd_count_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            fwd_count_q <= fwd_count_d;
        end
    end
endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed vector table, hand sequences for stall,
// flush, async reset and saturation, and random traffic against a reference model.
module tb_alu_operand_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_operand_stage_if #(.XLEN(64), .RADDR_W(5), .CNT_W(32)) bif ();
    alu_operand_stage_if #(.XLEN(64), .RADDR_W(5), .CNT_W(2))  sif ();

    alu_operand_stage #(.XLEN(64), .RADDR_W(5), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bif));
    alu_operand_stage #(.XLEN(64), .RADDR_W(5), .CNT_W(2))  dut_sat (.clk(clk), .rst(rst), .bus(sif));

    // Small-counter instance sees identical stimulus.
    assign sif.in_valid      = bif.in_valid;
    assign sif.pc            = bif.pc;
    assign sif.rs1_addr      = bif.rs1_addr;
    assign sif.rs1_data      = bif.rs1_data;
    assign sif.rs2_addr      = bif.rs2_addr;
    assign sif.rs2_data      = bif.rs2_data;
    assign sif.imm           = bif.imm;
    assign sif.asel          = bif.asel;
    assign sif.bsel          = bif.bsel;
    assign sif.fwd_ex_valid  = bif.fwd_ex_valid;
    assign sif.fwd_ex_rd     = bif.fwd_ex_rd;
    assign sif.fwd_ex_data   = bif.fwd_ex_data;
    assign sif.fwd_mem_valid = bif.fwd_mem_valid;
    assign sif.fwd_mem_rd    = bif.fwd_mem_rd;
    assign sif.fwd_mem_data  = bif.fwd_mem_data;
    assign sif.flush         = bif.flush;
    assign sif.out_ready     = bif.out_ready;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    logic        m_valid;
    logic [63:0] m_a, m_b;
    logic [31:0] m_cnt;
    int          m_sat;

    typedef struct {
        logic [1:0]  asel;
        logic [1:0]  bsel;
        logic [63:0] pc;
        logic [4:0]  rs1a;
        logic [63:0] rs1d;
        logic [4:0]  rs2a;
        logic [63:0] rs2d;
        logic [63:0] imm;
        logic        exv;
        logic [4:0]  exrd;
        logic [63:0] exd;
        logic        memv;
        logic [4:0]  memrd;
        logic [63:0] memd;
        logic [63:0] ea;
        logic [63:0] eb;
        logic        ef;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Operand value per the selection/forwarding rules; bit 64 flags a used forward.
    function automatic logic [64:0] opnd(input bit is_a);
        logic [1:0]  sel;
        logic [4:0]  addr;
        logic [63:0] rf;
        sel  = is_a ? bif.asel : bif.bsel;
        addr = is_a ? bif.rs1_addr : bif.rs2_addr;
        rf   = is_a ? bif.rs1_data : bif.rs2_data;
        if (sel == 2'd1) begin
            if (addr == 5'd0) return {1'b0, rf};
            if (bif.fwd_ex_valid && bif.fwd_ex_rd == addr) return {1'b1, bif.fwd_ex_data};
            if (bif.fwd_mem_valid && bif.fwd_mem_rd == addr) return {1'b1, bif.fwd_mem_data};
            return {1'b0, rf};
        end
        if (sel == 2'd2) return {1'b0, (is_a ? bif.pc : bif.imm)};
        if (sel == 2'd3 && !is_a) return {1'b0, 64'd4};
        return 65'd0;
    endfunction

    task automatic mdl_reset();
        m_valid = 1'b0; m_a = '0; m_b = '0; m_cnt = '0; m_sat = 0;
    endtask

    task automatic mdl_step();
        logic [64:0] oa, ob;
        logic acc;
        oa  = opnd(1'b1);
        ob  = opnd(1'b0);
        acc = bif.in_valid && (!m_valid || bif.out_ready) && !bif.flush;
        if (bif.flush) m_valid = 1'b0;
        else if (acc) begin
            m_valid = 1'b1;
            m_a = oa[63:0];
            m_b = ob[63:0];
            if (oa[64] || ob[64]) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
                if (m_sat < 3) m_sat = m_sat + 1;
            end
        end else if (bif.out_ready) m_valid = 1'b0;
    endtask

    task automatic tick();
        mdl_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".out_valid"}, 64'(bif.out_valid), 64'(m_valid));
        chk({tag, ".in_ready"},  64'(bif.in_ready), 64'(!m_valid || bif.out_ready));
        chk({tag, ".alu_a"},     bif.alu_a, m_a);
        chk({tag, ".alu_b"},     bif.alu_b, m_b);
        chk({tag, ".fwd_count"}, 64'(bif.fwd_count), 64'(m_cnt));
        chk({tag, ".sat_count"}, 64'(sif.fwd_count), 64'(m_sat));
    endtask

    task automatic idle();
        bif.in_valid = 0; bif.pc = '0; bif.rs1_addr = '0; bif.rs1_data = '0;
        bif.rs2_addr = '0; bif.rs2_data = '0; bif.imm = '0; bif.asel = '0; bif.bsel = '0;
        bif.fwd_ex_valid = 0; bif.fwd_ex_rd = '0; bif.fwd_ex_data = '0;
        bif.fwd_mem_valid = 0; bif.fwd_mem_rd = '0; bif.fwd_mem_data = '0;
        bif.flush = 0; bif.out_ready = 1;
    endtask

    task automatic apply_vec(input vec_t v);
        bif.asel = v.asel; bif.bsel = v.bsel; bif.pc = v.pc;
        bif.rs1_addr = v.rs1a; bif.rs1_data = v.rs1d;
        bif.rs2_addr = v.rs2a; bif.rs2_data = v.rs2d; bif.imm = v.imm;
        bif.fwd_ex_valid = v.exv; bif.fwd_ex_rd = v.exrd; bif.fwd_ex_data = v.exd;
        bif.fwd_mem_valid = v.memv; bif.fwd_mem_rd = v.memrd; bif.fwd_mem_data = v.memd;
    endtask

    initial begin
        int tcnt;
        logic [31:0] cnt_before;

        vecs[0] = '{2'd2, 2'd3, 64'h1000, 5'd0, 64'h0, 5'd0, 64'h0, 64'h0,
                    1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 64'h1000, 64'h4, 1'b0};
        vecs[1] = '{2'd1, 2'd0, 64'h0, 5'd5, 64'h11, 5'd0, 64'h0, 64'h0,
                    1'b1, 5'd5, 64'h22, 1'b1, 5'd5, 64'h33, 64'h22, 64'h0, 1'b1};
        vecs[2] = '{2'd1, 2'd0, 64'h0, 5'd5, 64'h11, 5'd0, 64'h0, 64'h0,
                    1'b0, 5'd5, 64'h22, 1'b1, 5'd5, 64'h33, 64'h33, 64'h0, 1'b1};
        vecs[3] = '{2'd1, 2'd0, 64'h0, 5'd0, 64'h0, 5'd0, 64'h0, 64'h0,
                    1'b1, 5'd0, 64'hFF, 1'b1, 5'd0, 64'hEE, 64'h0, 64'h0, 1'b0};
        vecs[4] = '{2'd0, 2'd2, 64'h0, 5'd0, 64'h0, 5'd7, 64'h55, 64'h7,
                    1'b1, 5'd7, 64'h99, 1'b0, 5'd0, 64'h0, 64'h0, 64'h7, 1'b0};
        vecs[5] = '{2'd3, 2'd1, 64'h1000, 5'd7, 64'h1, 5'd7, 64'h55, 64'h0,
                    1'b0, 5'd7, 64'h99, 1'b1, 5'd7, 64'h66, 64'h0, 64'h66, 1'b1};
        vecs[6] = '{2'd1, 2'd1, 64'h0, 5'd3, 64'h1, 5'd4, 64'h2, 64'h0,
                    1'b1, 5'd3, 64'hAA, 1'b1, 5'd4, 64'hBB, 64'hAA, 64'hBB, 1'b1};
        vecs[7] = '{2'd1, 2'd1, 64'h0, 5'd9, 64'h1234, 5'd10, 64'h5678, 64'h0,
                    1'b1, 5'd11, 64'hCC, 1'b1, 5'd12, 64'hDD, 64'h1234, 64'h5678, 1'b0};
        vecs[8] = '{2'd0, 2'd1, 64'h0, 5'd0, 64'h0, 5'd0, 64'h9, 64'h0,
                    1'b1, 5'd0, 64'hEE, 1'b1, 5'd0, 64'hEF, 64'h0, 64'h9, 1'b0};

        idle();
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.out_valid", 64'(bif.out_valid), 64'd0);
        chk("reset.in_ready",  64'(bif.in_ready), 64'd1);
        chk("reset.alu_a",     bif.alu_a, 64'd0);
        chk("reset.alu_b",     bif.alu_b, 64'd0);
        chk("reset.fwd_count", 64'(bif.fwd_count), 64'd0);
        rst = 1'b0;

        // Directed vector table, one accept per vector with EX always ready.
        tcnt = 0;
        bif.in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            apply_vec(vecs[i]);
            tick();
            tcnt += int'(vecs[i].ef);
            chk($sformatf("vec%0d.out_valid", i), 64'(bif.out_valid), 64'd1);
            chk($sformatf("vec%0d.alu_a", i), bif.alu_a, vecs[i].ea);
            chk($sformatf("vec%0d.alu_b", i), bif.alu_b, vecs[i].eb);
            chk($sformatf("vec%0d.fwd_count", i), 64'(bif.fwd_count), 64'(tcnt));
            chk($sformatf("vec%0d.sat_count", i), 64'(sif.fwd_count), 64'((tcnt > 3) ? 3 : tcnt));
        end
        bif.in_valid = 1'b0;
        tick();
        chk("drain.out_valid", 64'(bif.out_valid), 64'd0);

        // Stall hold: pair (0xA,0xB) held while new data waits and forwarding changes.
        idle();
        bif.in_valid = 1; bif.asel = 2'd1; bif.bsel = 2'd1;
        bif.rs1_addr = 5'd1; bif.rs1_data = 64'hA; bif.rs2_addr = 5'd2; bif.rs2_data = 64'hB;
        tick();
        chk("stall.load_a", bif.alu_a, 64'hA);
        chk("stall.load_b", bif.alu_b, 64'hB);
        bif.out_ready = 0; bif.rs1_data = 64'hC; bif.rs2_data = 64'hD;
        for (int i = 0; i < 3; i++) begin
            bif.fwd_ex_valid = 1; bif.fwd_ex_rd = 5'd1; bif.fwd_ex_data = 64'h77 + 64'(i);
            #1;
            chk($sformatf("stall%0d.in_ready", i), 64'(bif.in_ready), 64'd0);
            tick();
            chk($sformatf("stall%0d.out_valid", i), 64'(bif.out_valid), 64'd1);
            chk($sformatf("stall%0d.alu_a", i), bif.alu_a, 64'hA);
            chk($sformatf("stall%0d.alu_b", i), bif.alu_b, 64'hB);
        end
        bif.fwd_ex_valid = 0;
        bif.out_ready = 1;
        tick();
        chk("unstall.out_valid", 64'(bif.out_valid), 64'd1);
        chk("unstall.alu_a", bif.alu_a, 64'hC);
        chk("unstall.alu_b", bif.alu_b, 64'hD);

        // Flush with a forwarding instruction arriving while a pair is held.
        cnt_before = m_cnt;
        bif.out_ready = 0; bif.flush = 1;
        bif.rs1_data = 64'hE; bif.fwd_mem_valid = 1; bif.fwd_mem_rd = 5'd1; bif.fwd_mem_data = 64'h99;
        tick();
        chk("flush.out_valid", 64'(bif.out_valid), 64'd0);
        chk("flush.alu_a", bif.alu_a, 64'hC);
        chk("flush.alu_b", bif.alu_b, 64'hD);
        chk("flush.fwd_count", 64'(bif.fwd_count), 64'(cnt_before));
        bif.flush = 0;
        chk_model("post_flush");

        // Async reset pulse between edges while stalled.
        tick();
        bif.in_valid = 0;
        tick();
        chk("prerst.out_valid", 64'(bif.out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst.out_valid", 64'(bif.out_valid), 64'd0);
        chk("async_rst.fwd_count", 64'(bif.fwd_count), 64'd0);
        chk("async_rst.in_ready", 64'(bif.in_ready), 64'd1);
        rst = 1'b0;
        mdl_reset();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            bif.in_valid      = ($urandom_range(0, 3) != 0);
            bif.out_ready     = ($urandom_range(0, 3) != 0);
            bif.flush         = ($urandom_range(0, 11) == 0);
            bif.asel          = 2'($urandom_range(0, 3));
            bif.bsel          = 2'($urandom_range(0, 3));
            bif.pc            = {$urandom, $urandom};
            bif.imm           = {$urandom, $urandom};
            bif.rs1_addr      = 5'($urandom_range(0, 3));
            bif.rs2_addr      = 5'($urandom_range(0, 3));
            bif.rs1_data      = {$urandom, $urandom};
            bif.rs2_data      = {$urandom, $urandom};
            bif.fwd_ex_valid  = 1'($urandom_range(0, 1));
            bif.fwd_ex_rd     = 5'($urandom_range(0, 3));
            bif.fwd_ex_data   = {$urandom, $urandom};
            bif.fwd_mem_valid = 1'($urandom_range(0, 1));
            bif.fwd_mem_rd    = 5'($urandom_range(0, 3));
            bif.fwd_mem_data  = {$urandom, $urandom};
            tick();
            chk_model($sformatf("rand%0d", i));
        end

        // Saturation: five forwarded accepts after reset.
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mdl_reset();
        bif.in_valid = 1; bif.asel = 2'd1; bif.rs1_addr = 5'd1;
        bif.fwd_ex_valid = 1; bif.fwd_ex_rd = 5'd1; bif.fwd_ex_data = 64'h5;
        repeat (5) tick();
        chk("sat.fwd_count_small", 64'(sif.fwd_count), 64'd3);
        chk("sat.fwd_count_wide", 64'(bif.fwd_count), 64'd5);
        chk("sat.alu_a", bif.alu_a, 64'h5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Registered ALU operand-select stage at the ID/EX boundary of the 64-bit core; successor to the combinational operand-A select.
- Selects both ALU operands (A and B) with parametrised width.
- Adds EX/MEM result forwarding, a valid/ready pipeline register with stall hold and flush, and a forwarding-event counter.

Parameters:
- XLEN, 64, datapath width of all data ports and operand outputs.
- RADDR_W, 5, register-address width.
- CNT_W, 32, width of forwarding-event counter (saturating).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  decode stage presents an instruction.
- in_ready  output  1  stage can accept this cycle.
- pc  input  XLEN  instruction PC.
- rs1_addr  input  RADDR_W  source register 1 index.
- rs1_data  input  XLEN  register-file read data 1.
- rs2_addr  input  RADDR_W  source register 2 index.
- rs2_data  input  XLEN  register-file read data 2.
- imm  input  XLEN  sign-extended immediate.
- asel  input  2  A select: 00 zero, 01 rs1, 10 pc, 11 zero (reserved).
- bsel  input  2  B select: 00 zero, 01 rs2, 10 imm, 11 constant 4.
- fwd_ex_valid  input  1  EX stage result writes a register.
- fwd_ex_rd  input  RADDR_W  EX destination index.
- fwd_ex_data  input  XLEN  EX result.
- fwd_mem_valid  input  1  MEM stage result writes a register.
- fwd_mem_rd  input  RADDR_W  MEM destination index.
- fwd_mem_data  input  XLEN  MEM result.
- flush  input  1  kill held and incoming instruction.
- out_valid  output  1  alu_a/alu_b hold a valid operand pair.
- out_ready  input  1  EX stage consumes the pair.
- alu_a  output  XLEN  registered operand A.
- alu_b  output  XLEN  registered operand B.
- fwd_count  output  CNT_W  number of accepted instructions that used any forwarded operand.

Behaviour:
- Reset (async, rst=1): out_valid=0, alu_a=0, alu_b=0, fwd_count=0. in_ready=1 immediately, since it is combinational from out_valid.
- in_ready = !out_valid || out_ready (combinational; no dependence on in_valid).
- Accept = in_valid && in_ready && !flush.
- On accept, at the next edge:
  - alu_a/alu_b load the selected, forwarded values.
  - out_valid=1.
  - Latency is one cycle.
- No accept and out_ready=1: out_valid clears next edge. alu_a/alu_b keep their old values (don't-care content).
- No accept and out_ready=0: hold out_valid, alu_a and alu_b unchanged (stall).
- Flush (highest priority):
  - out_valid=0 next edge.
  - The incoming instruction is discarded.
  - fwd_count is not incremented.
  - alu_a/alu_b unchanged.
- Forwarding, per source (rs1 for A, rs2 for B), resolved combinationally before the register:
  - If fwd_ex_valid && fwd_ex_rd==addr && addr!=0, use fwd_ex_data.
  - Else if fwd_mem_valid && fwd_mem_rd==addr && addr!=0, use fwd_mem_data.
  - Else use the register-file data.
  - EX has priority over MEM. x0 is never forwarded and reads the register-file value.
- Forwarding applies only when the corresponding select uses the register: asel=01 or bsel=01. A match on an unselected source has no effect and does not count.
- Constant 4 is zero-extended to XLEN.
- fwd_count increments by 1 on an accept where at least one selected operand was forwarded (A and B both forwarded still counts 1). It saturates at all-ones.
- Forwarding data is sampled only at the accept edge. Changes to fwd_* during a stall do not alter held operands; the hazard unit stalls decode instead.
- Reset asserted mid-stall clears out_valid at once. The held pair is lost.

Test Plan:
- Reset then single issue: asel=10, bsel=11, pc=0x1000, in_valid=1, out_ready=1 -> next cycle out_valid=1, alu_a=0x1000, alu_b=0x4; fwd_count=0.
- Forward priority: rs1_addr=5, rs1_data=0x11, fwd_ex(rd=5, data=0x22), fwd_mem(rd=5, data=0x33), asel=01 -> alu_a=0x22. With fwd_ex_valid=0 -> alu_a=0x33. fwd_count increments once per accept.
- x0 and unselected sources:
  - rs1_addr=0, fwd_ex(rd=0, data=0xFF), rs1_data=0, asel=01 -> alu_a=0, no count.
  - rs2 match with bsel=10, imm=0x7 -> alu_b=0x7, no count.
- Stall hold: accept pair (0xA, 0xB), then out_ready=0 for 3 cycles while in_valid=1 with new data -> in_ready=0, alu_a=0xA, alu_b=0xB, out_valid=1 throughout. Raise out_ready -> next pair loads the following cycle.
- Flush: flush=1 together with in_valid=1 while out_valid=1 -> next cycle out_valid=0, fwd_count unchanged even if the incoming instruction forwarded.
- Async reset mid-stall: rst pulse between edges -> out_valid=0 and fwd_count=0 before the next clock edge. Counter saturation with CNT_W=2: 5 forwarded accepts -> fwd_count=3.
